chunked_adder_seq: RTL and testbench

Parametrised multi-cycle ripple adder/subtractor: adds two WIDTH-bit operands CHUNK bits per clock, carrying between chunks in a register, and delivers sum, carry-out, signed overflow and zero flags. Replaces fixed-width combinational adders where a long ripple chain would set the critical path, e.g. the PC/branch-target datapath and a future multi-cycle ALU. Operands enter and results leave on valid/ready handshakes.

---
 rtl/adder_pkg.sv | 28 ++
 rtl/chunked_adder_seq_if.sv | 35 +++
 rtl/adder_chunk.sv | 44 ++++
 rtl/chunked_adder_seq.sv | 127 ++++++++++++
 tb/tb_chunked_adder_seq.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared types and helpers for the chunked sequential adder.
//  Revision    : 1.0  initial release
// ============================================================================
package adder_pkg;

    // Controller states of the chunked adder
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Evaluates to 1 when WIDTH splits evenly into CHUNK-bit slices, else 0.
    // Used as a divisor so that an illegal combination fails elaboration.
    function automatic int width_ok(input int width, input int chunk);
        return ((chunk > 0) && (width % chunk == 0)) ? 1 : 0;
    endfunction

    // Chunk index width: clog2(n), never below one bit
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/chunked_adder_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : chunked_adder_seq_if
//  Description : Operand/result handshake bundle of the chunked adder.
//  Revision    : 1.0  initial release
// ============================================================================
interface chunked_adder_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    // Requester / result consumer side
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    // Adder side
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface
`default_nettype wire

// File: rtl/adder_chunk.sv
`default_nettype none
// ============================================================================
//  Module      : adder_chunk / full_adder1
//  Description : CHUNK-bit combinational ripple adder built from 1-bit cells.
//  Revision    : 1.0  initial release
// ============================================================================
module full_adder1 (
    input  wire logic a,
    input  wire logic b,
    input  wire logic c,
    output logic      s,
    output logic      cout
);
    assign s    = a ^ b ^ c;
    assign cout = (a & b) | (c & (a ^ b));
endmodule

module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  wire logic [CHUNK-1:0] a,
    input  wire logic [CHUNK-1:0] b,
    input  wire logic             c,
    output logic      [CHUNK-1:0] s,
    output logic                  cout
);
    logic [CHUNK:0] w_c;

    assign w_c[0] = c;

    // One full-adder cell per bit, carry rippling upward
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder1 u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .c    (w_c[i]),
            .s    (s[i]),
            .cout (w_c[i+1])
        );
    end

    assign cout = w_c[CHUNK];
endmodule
`default_nettype wire

// File: rtl/chunked_adder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : chunked_adder_seq
//  Description : Multi-cycle adder/subtractor, CHUNK bits per clock, carry
//                held in a register between chunks; sum/cout/ovf/zero out.
//  Revision    : 1.0  initial release
// ============================================================================
module chunked_adder_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    chunked_adder_seq_if.slave bus
);
    // Division by zero here stops elaboration when WIDTH % CHUNK != 0
    localparam int c_WIDTH_OK = width_ok(WIDTH, CHUNK);
    localparam int c_N        = WIDTH / CHUNK / c_WIDTH_OK;
    localparam int c_IDXW     = idx_width(c_N);
    localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(c_N - 1);

    state_t            state_q, state_d;
    logic [c_IDXW-1:0] idx_q;
    logic [WIDTH-1:0]  a_q, b_q;      // b_q already holds b or ~b
    logic [WIDTH-1:0]  acc_q;         // partial sum, internal only
    logic              carry_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q, ovf_q, zero_q;

    logic [CHUNK-1:0]  w_a_chunk, w_b_chunk, w_s_chunk;
    logic              w_c_chunk;
    logic [WIDTH-1:0]  w_final;
    logic              w_last;

    // Select the current slice of each operand
    always_comb begin
        w_a_chunk = a_q[int'(idx_q)*CHUNK +: CHUNK];
        w_b_chunk = b_q[int'(idx_q)*CHUNK +: CHUNK];
        w_last    = (idx_q == c_LAST);
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (w_a_chunk),
        .b    (w_b_chunk),
        .c    (carry_q),
        .s    (w_s_chunk),
        .cout (w_c_chunk)
    );

    // Partial sum with this cycle's slice merged in; complete on the last chunk
    always_comb begin
        w_final = acc_q;
        w_final[int'(idx_q)*CHUNK +: CHUNK] = w_s_chunk;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid)  state_d = S_RUN;
            S_RUN:   if (w_last)        state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; in_ready is forced low during reset
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE) && !rst;
        bus.out_valid = (state_q == S_DONE);
    end

    // Operand capture, per-chunk accumulation and final result registration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub ? 1'b1 : bus.cin;
                        idx_q   <= '0;
                    end
                end
                S_RUN: begin
                    acc_q   <= w_final;
                    carry_q <= w_c_chunk;
                    if (w_last) begin
                        sum_q  <= w_final;
                        cout_q <= w_c_chunk;
                        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (w_final[WIDTH-1] != a_q[WIDTH-1]);
                        zero_q <= (w_final == '0);
                    end else begin
                        idx_q  <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_chunked_adder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chunked_adder_seq
//  Description : Self-checking bench for chunked_adder_seq (32/8, 32/32, 30/10).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_chunked_adder_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chunked_adder_seq_if #(.WIDTH(32)) bus8  ();
    chunked_adder_seq_if #(.WIDTH(32)) bus32 ();
    chunked_adder_seq_if #(.WIDTH(30)) bus30 ();

    chunked_adder_seq #(.WIDTH(32), .CHUNK(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
    chunked_adder_seq #(.WIDTH(32), .CHUNK(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
    chunked_adder_seq #(.WIDTH(30), .CHUNK(10)) u_dut30 (.clk(clk), .rst(rst), .bus(bus30));

    int n_checks = 0;
    int n_pass   = 0;

    localparam longint c_SMAX = 64'sd2147483647;
    localparam longint c_SMIN = -64'sd2147483648;

    // Reference: {cout, ovf, zero, sum} from integer arithmetic on the operands
    function automatic logic [34:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic sub);
        longint          sa, sb, sres;
        logic [63:0]     ua, ub, ures;
        logic            c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        if (sub) begin
            sres = sa - sb;
            ures = ua - ub;
            c    = (a >= b);
        end else begin
            sres = sa + sb + longint'(cin);
            ures = ua + ub + 64'(cin);
            c    = (ures >= 64'h1_0000_0000);
        end
        v = (sres > c_SMAX) || (sres < c_SMIN);
        return {c, v, (ures[31:0] == 32'd0), ures[31:0]};
    endfunction

    // Issue one operation on the 32/8 instance; scramble inputs after accept
    // and count edges until out_valid (bounded).
    task automatic run8(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, output int lat, output logic timed_out);
        @(negedge clk);
        bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        bus8.a = $urandom; bus8.b = $urandom; bus8.cin = 1'($urandom); bus8.sub = 1'($urandom);
        lat = 0; timed_out = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            lat++;
            if (bus8.out_valid === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic ack8();
        @(negedge clk); bus8.out_ready = 1'b1;
        @(posedge clk); #1; bus8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus8.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus8.in_ready); else n_pass++;
        n_checks++; if ({bus8.out_valid, bus8.sum, bus8.cout, bus8.ovf, bus8.zero} !== 36'd0)
            $display("FAIL reset_outputs: got ov=%b sum=%h c=%b v=%b z=%b want all 0",
                     bus8.out_valid, bus8.sum, bus8.cout, bus8.ovf, bus8.zero); else n_pass++;
        @(negedge clk); rst = 1'b0; #1;
        n_checks++; if (bus8.in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", bus8.in_ready); else n_pass++;
    endtask

    task automatic test_carry_zero();
        int lat; logic to;
        run8(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, lat, to);
        n_checks++; if (to !== 1'b0 || lat !== 4) $display("FAIL carry_latency: got %0d (timeout %b) want 4", lat, to); else n_pass++;
        n_checks++; if ({bus8.sum, bus8.cout, bus8.zero, bus8.ovf} !== {32'h0, 1'b1, 1'b1, 1'b0})
            $display("FAIL carry_zero: got sum=%h c=%b z=%b v=%b want sum=0 c=1 z=1 v=0",
                     bus8.sum, bus8.cout, bus8.zero, bus8.ovf); else n_pass++;
        ack8();
    endtask

    task automatic test_overflow();
        int lat; logic to;
        run8(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, lat, to);
        n_checks++; if (to !== 1'b0 || {bus8.sum, bus8.ovf, bus8.cout, bus8.zero} !== {32'h8000_0000, 1'b1, 1'b0, 1'b0})
            $display("FAIL overflow: got sum=%h v=%b c=%b z=%b want sum=80000000 v=1 c=0 z=0",
                     bus8.sum, bus8.ovf, bus8.cout, bus8.zero); else n_pass++;
        ack8();
    endtask

    task automatic test_subtract();
        int lat; logic to;
        run8(32'd5, 32'd7, 1'b1, 1'b1, lat, to);
        n_checks++; if (to !== 1'b0 || {bus8.sum, bus8.cout, bus8.ovf, bus8.zero} !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0})
            $display("FAIL sub_borrow: got sum=%h c=%b v=%b z=%b want sum=fffffffe c=0 v=0 z=0",
                     bus8.sum, bus8.cout, bus8.ovf, bus8.zero); else n_pass++;
        ack8();
        run8(32'd7, 32'd5, 1'b0, 1'b1, lat, to);
        n_checks++; if (to !== 1'b0 || {bus8.sum, bus8.cout, bus8.ovf, bus8.zero} !== {32'd2, 1'b1, 1'b0, 1'b0})
            $display("FAIL sub_no_borrow: got sum=%h c=%b v=%b z=%b want sum=2 c=1 v=0 z=0",
                     bus8.sum, bus8.cout, bus8.ovf, bus8.zero); else n_pass++;
        ack8();
    endtask

    task automatic test_random();
        int lat; logic to; logic [31:0] a, b; logic cin, sub; logic [34:0] exp;
        for (int i = 0; i < 30; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            if (i % 5 == 0) b = sub ? a : (~a + 32'(!cin));   // force zero results
            exp = model32(a, b, cin, sub);
            run8(a, b, cin, sub, lat, to);
            n_checks++; if (to !== 1'b0 || lat !== 4 || {bus8.cout, bus8.ovf, bus8.zero, bus8.sum} !== exp)
                $display("FAIL random[%0d]: a=%h b=%h cin=%b sub=%b got lat=%0d c=%b v=%b z=%b sum=%h want lat=4 c=%b v=%b z=%b sum=%h",
                         i, a, b, cin, sub, lat, bus8.cout, bus8.ovf, bus8.zero, bus8.sum,
                         exp[34], exp[33], exp[32], exp[31:0]); else n_pass++;
            ack8();
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic to; logic [31:0] a, b; logic [34:0] exp;
        a = $urandom; b = $urandom;
        exp = model32(a, b, 1'b0, 1'b0);
        run8(a, b, 1'b0, 1'b0, lat, to);
        @(negedge clk);
        bus8.a = 32'd1; bus8.b = 32'd2; bus8.sub = 1'b0; bus8.cin = 1'b0; bus8.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_checks++; if (to !== 1'b0 || bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0 ||
                            {bus8.cout, bus8.ovf, bus8.zero, bus8.sum} !== exp)
                $display("FAIL backpressure_hold[%0d]: got ov=%b ir=%b sum=%h want ov=1 ir=0 sum=%h",
                         k, bus8.out_valid, bus8.in_ready, bus8.sum, exp[31:0]); else n_pass++;
        end
        @(negedge clk); bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
        n_checks++; if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1)
            $display("FAIL handshake_return: got ov=%b ir=%b want ov=0 ir=1", bus8.out_valid, bus8.in_ready); else n_pass++;
        to = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus8.out_valid !== 1'b0 || bus8.sum !== exp[31:0]) to = 1'b1;
        end
        n_checks++; if (to !== 1'b0)
            $display("FAIL no_accept_on_handshake: got ov=%b sum=%h want ov=0 sum=%h", bus8.out_valid, bus8.sum, exp[31:0]); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int lat; logic to;
        @(negedge clk);
        bus8.a = 32'd9; bus8.b = 32'd9; bus8.cin = 1'b0; bus8.sub = 1'b0; bus8.in_valid = 1'b1;
        @(posedge clk); #1; bus8.in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1; #1;
        n_checks++; if (bus8.out_valid !== 1'b0 || bus8.sum !== 32'd0 || bus8.in_ready !== 1'b0)
            $display("FAIL midrun_reset: got ov=%b sum=%h ir=%b want ov=0 sum=0 ir=0", bus8.out_valid, bus8.sum, bus8.in_ready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus8.in_ready !== 1'b0) $display("FAIL midrun_ready_in_rst: got %b want 0", bus8.in_ready); else n_pass++;
        @(negedge clk); rst = 1'b0; #1;
        n_checks++; if (bus8.in_ready !== 1'b1) $display("FAIL midrun_ready_after: got %b want 1", bus8.in_ready); else n_pass++;
        to = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (bus8.out_valid !== 1'b0) to = 1'b1; end
        n_checks++; if (to !== 1'b0) $display("FAIL midrun_discard: got ov=1 want ov=0"); else n_pass++;
        run8(32'd3, 32'd4, 1'b0, 1'b0, lat, to);
        n_checks++; if (to !== 1'b0 || lat !== 4 || bus8.sum !== 32'd7)
            $display("FAIL after_reset_op: got sum=%h lat=%0d want sum=7 lat=4", bus8.sum, lat); else n_pass++;
        ack8();
    endtask

    task automatic test_param_sweep();
        int lat; logic to; logic [31:0] a, b; logic [34:0] exp;
        // CHUNK == WIDTH: single RUN cycle
        a = $urandom; b = $urandom;
        exp = model32(a, b, 1'b1, 1'b0);
        @(negedge clk);
        bus32.a = a; bus32.b = b; bus32.cin = 1'b1; bus32.sub = 1'b0; bus32.in_valid = 1'b1;
        @(posedge clk); #1; bus32.in_valid = 1'b0;
        lat = 0; to = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1; lat++;
            if (bus32.out_valid === 1'b1) begin to = 1'b0; break; end
        end
        n_checks++; if (to !== 1'b0 || lat !== 1 || {bus32.cout, bus32.ovf, bus32.zero, bus32.sum} !== exp)
            $display("FAIL sweep_32_32: got lat=%0d sum=%h c=%b want lat=1 sum=%h c=%b", lat, bus32.sum, bus32.cout, exp[31:0], exp[34]); else n_pass++;
        @(negedge clk); bus32.out_ready = 1'b1; @(posedge clk); #1; bus32.out_ready = 1'b0;
        // WIDTH=30, CHUNK=10: full carry ripple across three chunks
        @(negedge clk);
        bus30.a = 30'h3FFF_FFFF; bus30.b = 30'd0; bus30.cin = 1'b1; bus30.sub = 1'b0; bus30.in_valid = 1'b1;
        @(posedge clk); #1; bus30.in_valid = 1'b0;
        lat = 0; to = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1; lat++;
            if (bus30.out_valid === 1'b1) begin to = 1'b0; break; end
        end
        n_checks++; if (to !== 1'b0 || lat !== 3 || {bus30.sum, bus30.cout, bus30.zero, bus30.ovf} !== {30'd0, 1'b1, 1'b1, 1'b0})
            $display("FAIL sweep_30_10: got lat=%0d sum=%h c=%b z=%b v=%b want lat=3 sum=0 c=1 z=1 v=0",
                     lat, bus30.sum, bus30.cout, bus30.zero, bus30.ovf); else n_pass++;
        @(negedge clk); bus30.out_ready = 1'b1; @(posedge clk); #1; bus30.out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0; bus8.sub  = 1'b0; bus8.out_ready  = 1'b0;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0; bus32.out_ready = 1'b0;
        bus30.in_valid = 1'b0; bus30.a = '0; bus30.b = '0; bus30.cin = 1'b0; bus30.sub = 1'b0; bus30.out_ready = 1'b0;
        test_reset();
        test_carry_zero();
        test_overflow();
        test_subtract();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_param_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
